// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and helpers for the two-master RAM port arbiter.
package ram_arb_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } mem_rsp_t;

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_e;

  // Offset is relative to the window base; the extra bit lets a window of 2**32 bytes compare cleanly.
  function automatic logic in_window(input logic [31:0] off, input int unsigned addr_width);
    logic [32:0] window_bytes;
    window_bytes = 33'(BYTES_PER_WORD) << addr_width;
    return {1'b0, off} < window_bytes;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Core-style req/gnt/rvalid master bus and the dp_ram port bus driven by the arbiter.
interface mem_bus_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

interface ram_port_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  en;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic [31:0]           rdata;

  modport master (
    output en, addr, we, be, wdata,
    input  rdata
  );

  modport slave (
    input  en, addr, we, be, wdata,
    output rdata
  );
endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; the priority pointer moves only when both inputs contend.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q;  // 0: input 0 wins the next contention

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (&req) begin
      ptr_q <= ~ptr_q;
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter and protocol adapter in front of one dp_ram port.
// Read data is returned one cycle after the grant; out-of-window accesses answer with err.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  mem_bus_if.slave       m0,
  mem_bus_if.slave       m1,
  ram_port_if.master     ram
);

  logic [1:0]  req;
  logic [1:0]  gnt;
  mem_req_t    m0_req;
  mem_req_t    m1_req;
  mem_req_t    sel_req;
  logic [31:0] off;
  logic        granted;
  logic        in_range;
  logic        access;

  logic        rsp_valid_q;
  owner_e      rsp_owner_q;
  logic        rsp_we_q;
  logic        rsp_err_q;
  logic        rsp_live;
  mem_rsp_t    m0_rsp;
  mem_rsp_t    m1_rsp;

  assign req = {m1.req, m0.req};

  rr_arb2 u_rr_arb2 (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign m0.gnt = gnt[0];
  assign m1.gnt = gnt[1];

  assign m0_req = '{addr: m0.addr, we: m0.we, be: m0.be, wdata: m0.wdata};
  assign m1_req = '{addr: m1.addr, we: m1.we, be: m1.be, wdata: m1.wdata};

  assign sel_req  = gnt[1] ? m1_req : m0_req;
  assign granted  = |gnt;
  assign off      = sel_req.addr - BASE_ADDR;
  assign in_range = in_window(off, ADDR_WIDTH);
  assign access   = granted & in_range;

  // The RAM port stays fully quiet unless an in-window access is granted this cycle.
  assign ram.en    = access;
  assign ram.addr  = access ? off[ADDR_WIDTH+1:2] : '0;
  assign ram.we    = access & sel_req.we;
  assign ram.be    = access ? sel_req.be : 4'h0;
  assign ram.wdata = access ? sel_req.wdata : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= OWNER_M0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else if (granted) begin
      rsp_valid_q <= 1'b1;
      rsp_owner_q <= owner_e'(gnt[1]);
      rsp_we_q    <= sel_req.we;
      rsp_err_q   <= ~in_range;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= OWNER_M0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end
  end

  // A response still in flight when rst rises is dropped in that same cycle.
  assign rsp_live = rsp_valid_q & ~rst;

  // ram.rdata toggles every cycle; it only passes through during the owner's read response.
  always_comb begin
    m0_rsp = '0;
    m1_rsp = '0;
    if (rsp_live) begin
      if (rsp_owner_q == OWNER_M0) begin
        m0_rsp.rvalid = 1'b1;
        m0_rsp.err    = rsp_err_q;
        m0_rsp.rdata  = (rsp_we_q || rsp_err_q) ? 32'h0 : ram.rdata;
      end else begin
        m1_rsp.rvalid = 1'b1;
        m1_rsp.err    = rsp_err_q;
        m1_rsp.rdata  = (rsp_we_q || rsp_err_q) ? 32'h0 : ram.rdata;
      end
    end
  end

  assign m0.rvalid = m0_rsp.rvalid;
  assign m0.rdata  = m0_rsp.rdata;
  assign m0.err    = m0_rsp.err;
  assign m1.rvalid = m1_rsp.rvalid;
  assign m1.rdata  = m1_rsp.rdata;
  assign m1.err    = m1_rsp.err;

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-master to one-RAM-port arbiter and protocol adapter.
- Sits directly upstream of one port (A or B) of dp_ram.
- Converts two core-style req/gnt/rvalid byte-addressed memory interfaces into dp_ram port signals (en/addr/we/be/wdata).
- Returns dp_ram's 1-cycle-latency read data to the owning master, with an error response for out-of-range accesses.

Parameters:
- ADDR_WIDTH, 8: dp_ram word-address width; window = 4*2**ADDR_WIDTH bytes.
- BASE_ADDR, 32'h0000_0000: byte base of the window; must be aligned to the window size.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req_i  in  1  master 0 request.
- m0_gnt_o  out  1  master 0 grant (combinational, same cycle as req).
- m0_addr_i  in  32  master 0 byte address.
- m0_we_i  in  1  master 0 write enable.
- m0_be_i  in  4  master 0 byte enables.
- m0_wdata_i  in  32  master 0 write data.
- m0_rvalid_o  out  1  master 0 response valid.
- m0_rdata_o  out  32  master 0 read data.
- m0_err_o  out  1  master 0 error, qualified by rvalid.
- m1_*: same set of ports and widths as m0_*, for master 1.
- ram_en_o  out  1  to dp_ram en.
- ram_addr_o  out  ADDR_WIDTH  to dp_ram addr (word address).
- ram_we_o  out  1  to dp_ram we.
- ram_be_o  out  4  to dp_ram be.
- ram_wdata_o  out  32  to dp_ram wdata.
- ram_rdata_i  in  32  from dp_ram rdata (registered, valid 1 cycle after access).

Behaviour:
- Reset values (registered outputs and state):
  - all rvalid and err = 0.
  - priority pointer = master 0.
  - response-owner, response-we and response-err registers = 0.
- gnt, ram_* and rdata are combinational; they must be 0 in every cycle with no request or response.
- Arbitration:
  - At most one grant per cycle.
  - Only one master requesting: that master is granted.
  - Both requesting: grant the master named by the priority pointer.
  - The pointer then flips to the other master. The pointer changes only on a contended grant.
- Address decode: off = addr - BASE_ADDR.
  - In range iff off < 4*2**ADDR_WIDTH.
  - ram_addr_o = off[ADDR_WIDTH+1:2]; addr[1:0] is ignored, and be selects bytes.
- Granted, in range: in the grant cycle ram_en_o = 1 and ram_we_o/be_o/wdata_o = the master's we/be/wdata.
- Granted, out of range: ram_en_o = 0 and ram_we_o = 0; the error flag is registered.
- Response:
  - Exactly one cycle after every grant, the granted master sees rvalid = 1 for one cycle.
  - err = 1 iff the access was out of range.
  - rdata = ram_rdata_i for an in-range read; rdata = 0 for writes and errors.
- Back-to-back: a new grant is allowed in the same cycle as the previous access's rvalid (fully pipelined, throughput 1 per cycle).
- Read-after-write: a write at cycle N followed by a read of the same word at N+1 returns the new data at N+2 (dp_ram write-first ordering across cycles).
- Request withdrawal without gnt: allowed, no side effects.
- Reset asserted while an rvalid is pending:
  - the pending response is discarded and rvalid is 0 in the next cycle.
  - gnt is forced to 0 and ram_en_o to 0 while rst = 1.
- ram_rdata_i changes every cycle, because dp_ram reads even when en = 0. It must never reach a master outside its own rvalid cycle.

Decomposition:
- Package ram_arb_pkg:
  - typedef mem_req_t: addr, we, be, wdata.
  - typedef mem_rsp_t: rvalid, rdata, err.
  - constant BYTES_PER_WORD = 4.
- Single natural sub-module rr_arb2: a 2-input round-robin arbiter holding the priority pointer, with the same clk/rst.
- Decode and response pipeline stay in the top module.

Test Plan:
- Single m0 write then read:
  - Stimulus: m0 writes 0xDEADBEEF, be = 4'hF, to addr 0x10; next cycle m0 reads 0x10.
  - Response: both grants are immediate; rvalid at +1 each; the read returns 0xDEADBEEF with err = 0.
- Contention:
  - Stimulus: m0 and m1 both request continuously for 4 cycles after reset.
  - Response: grants go m0, m1, m0, m1; each rvalid goes only to its owner one cycle later.
- Partial write:
  - Stimulus: write 0x11223344 be = F to word 3, then 0xAABBCCDD be = 4'b0101.
  - Response: a read returns 0x11BB33DD.
- Out of range:
  - Stimulus: m1 reads BASE_ADDR + 4*2**ADDR_WIDTH.
  - Response: gnt = 1, ram_en_o = 0, then rvalid = 1 with err = 1 and rdata = 0.
- Reset mid-op:
  - Stimulus: m0 read granted at cycle N, rst = 1 at N+1.
  - Response: m0_rvalid_o = 0 at N+1 and N+2; the pointer is back to m0.
- Idle leakage:
  - Stimulus: no requests while the other dp_ram port writes.
  - Response: rvalid and rdata stay 0 on both masters.
